// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - in-order branch-update queue feeding the predictor table write port
// Optional idle bypass (1-cycle latency) is enabled by defining BP_UPD_BYPASS_EN.
module bp_update_scheduler #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int IDX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd0_valid,
  input  logic [WIDTH-1:0]      upd0_pc,
  input  logic                  upd0_taken,
  output logic                  upd0_ready,
  input  logic                  upd1_valid,
  input  logic [WIDTH-1:0]      upd1_pc,
  input  logic                  upd1_taken,
  output logic                  upd1_ready,
  input  logic                  clear_req,
  input  logic                  tbl_busy,
  output logic                  tbl_wr_en,
  output logic [IDX_BITS-1:0]   tbl_wr_idx,
  output logic                  tbl_wr_taken,
  output logic                  tbl_wr_clr,
  output logic                  clear_done,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IDX_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CLEAR} state_t;

  state_t              r_state, w_state_next;
  logic [EW-1:0]       r_q_data [DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count, w_count_next, w_free;
  logic [IDX_BITS-1:0] r_sweep_idx;
  logic                r_sweep_fin;
  logic                w_acc0, w_acc1, w_byp, w_push0, w_push1;
  logic                w_pop, w_sweep_wr, w_sweep_end;
  logic [EW-1:0]       w_lane0, w_lane1, w_first, w_byp_data;
  logic                w_unused_pc_hi;

  assign w_unused_pc_hi = ^{upd0_pc[WIDTH-1:IDX_BITS], upd1_pc[WIDTH-1:IDX_BITS]};
  assign w_lane0 = {upd0_pc[IDX_BITS-1:0], upd0_taken};
  assign w_lane1 = {upd1_pc[IDX_BITS-1:0], upd1_taken};

  // Ready uses the registered occupancy, so a same-cycle pop never frees a slot early.
  assign w_free     = CW'(DEPTH) - r_count;
  assign upd0_ready = (w_free >= CW'(1));
  assign upd1_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !upd0_valid);
  assign w_acc0     = upd0_valid && upd0_ready;
  assign w_acc1     = upd1_valid && upd1_ready;

`ifdef BP_UPD_BYPASS_EN
  assign w_byp = (r_state == S_IDLE) && (r_count == '0) && !tbl_busy && !clear_req
                 && (w_acc0 || w_acc1);
`else
  assign w_byp = 1'b0;
`endif

  assign w_byp_data   = w_acc0 ? w_lane0 : w_lane1;
  assign w_push0      = w_acc0 && !w_byp;
  assign w_push1      = w_acc1 && !(w_byp && !w_acc0);
  assign w_first      = w_push0 ? w_lane0 : w_lane1;
  assign w_count_next = r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
  assign q_count      = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear_req)              w_state_next = S_CLEAR;
        else if (w_push0 || w_push1) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (clear_req)                 w_state_next = S_CLEAR;
        else if (w_count_next == '0)   w_state_next = S_IDLE;
      end
      S_CLEAR: begin
        if (w_sweep_end) w_state_next = (w_count_next != '0) ? S_ACTIVE : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sweep finishes with one extra cycle in CLEAR that raises clear_done.
  always_comb begin
    w_pop       = 1'b0;
    w_sweep_wr  = 1'b0;
    w_sweep_end = 1'b0;
    case (r_state)
      S_ACTIVE: w_pop = !tbl_busy && !clear_req && (r_count != '0);
      S_CLEAR: begin
        w_sweep_wr  = !r_sweep_fin && !tbl_busy;
        w_sweep_end = r_sweep_fin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push0 || w_push1) r_q_data[r_wr_ptr] <= w_first;
    if (w_push0 && w_push1) r_q_data[r_wr_ptr + PW'(1)] <= w_lane1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_sweep_idx <= '0;
      r_sweep_fin <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push0) + PW'(w_push1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
      if (w_sweep_wr) begin
        r_sweep_idx <= r_sweep_idx + IDX_BITS'(1);
        if (r_sweep_idx == '1) r_sweep_fin <= 1'b1;
      end
      if (w_sweep_end) r_sweep_fin <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_wr_en    <= 1'b0;
      tbl_wr_idx   <= '0;
      tbl_wr_taken <= 1'b0;
      tbl_wr_clr   <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      clear_done <= w_sweep_end;
      if (w_byp) begin
        tbl_wr_en                  <= 1'b1;
        {tbl_wr_idx, tbl_wr_taken} <= w_byp_data;
        tbl_wr_clr                 <= 1'b0;
      end else if (w_pop) begin
        tbl_wr_en                  <= 1'b1;
        {tbl_wr_idx, tbl_wr_taken} <= r_q_data[r_rd_ptr];
        tbl_wr_clr                 <= 1'b0;
      end else if (w_sweep_wr) begin
        tbl_wr_en    <= 1'b1;
        tbl_wr_idx   <= r_sweep_idx;
        tbl_wr_taken <= 1'b0;
        tbl_wr_clr   <= 1'b1;
      end else begin
        tbl_wr_en    <= 1'b0;
        tbl_wr_idx   <= '0;
        tbl_wr_taken <= 1'b0;
        tbl_wr_clr   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - scoreboard bench for bp_update_scheduler
// Latency expectations follow BP_UPD_BYPASS_EN when it is defined.
module tb_bp_update_scheduler;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int IDX_BITS = 8;
  localparam int NIDX     = 1 << IDX_BITS;
`ifdef BP_UPD_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                taken;
    logic                clr;
  } exp_t;

  logic clk, rst;
  logic upd0_valid, upd0_taken, upd0_ready;
  logic upd1_valid, upd1_taken, upd1_ready;
  logic [WIDTH-1:0] upd0_pc, upd1_pc;
  logic clear_req, tbl_busy;
  logic tbl_wr_en, tbl_wr_taken, tbl_wr_clr, clear_done;
  logic [IDX_BITS-1:0] tbl_wr_idx;
  logic [$clog2(DEPTH):0] q_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int wr_cyc_q[$];
  int done_cyc_q[$];

  bp_update_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .rst(rst),
    .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_taken(upd0_taken), .upd0_ready(upd0_ready),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken), .upd1_ready(upd1_ready),
    .clear_req(clear_req), .tbl_busy(tbl_busy),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_taken(tbl_wr_taken),
    .tbl_wr_clr(tbl_wr_clr), .clear_done(clear_done), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk_exp(logic [WIDTH-1:0] pc, logic taken, logic clr);
    exp_t e;
    e.idx   = pc[IDX_BITS-1:0];
    e.taken = taken;
    e.clr   = clr;
    return e;
  endfunction

  // Scoreboard: every table write is popped against the next expected entry.
  always @(negedge clk) begin
    if (tbl_wr_en === 1'b1) begin
      exp_t e;
      wr_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected idx=%0h taken=%0b clr=%0b want no write", tbl_wr_idx, tbl_wr_taken, tbl_wr_clr);
      end else begin
        e = exp_q.pop_front();
        if ({tbl_wr_idx, tbl_wr_taken, tbl_wr_clr} !== e) begin
          errors++;
          $display("FAIL wr_data got idx=%0h t=%0b c=%0b want idx=%0h t=%0b c=%0b",
                   tbl_wr_idx, tbl_wr_taken, tbl_wr_clr, e.idx, e.taken, e.clr);
        end
      end
    end
    if (clear_done === 1'b1) done_cyc_q.push_back(cyc);
  end

  task automatic idle_inputs();
    upd0_valid = 0; upd0_pc = '0; upd0_taken = 0;
    upd1_valid = 0; upd1_pc = '0; upd1_taken = 0;
    clear_req = 0; tbl_busy = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({tbl_wr_en, tbl_wr_idx, tbl_wr_taken, tbl_wr_clr, clear_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0h want 0", {tbl_wr_en, tbl_wr_idx, tbl_wr_taken, tbl_wr_clr, clear_done});
    end
    checks++;
    if (q_count !== 0) begin errors++; $display("FAIL reset_q_count got %0d want 0", q_count); end
    checks++;
    if ({upd0_ready, upd1_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b want 11", {upd0_ready, upd1_ready});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    int acc;
    wr_cyc_q.delete();
    @(posedge clk); #1;
    upd0_valid = 1; upd0_pc = 32'h1234; upd0_taken = 1;
    acc = cyc;
    exp_q.push_back(mk_exp(32'h1234, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (upd0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", upd0_ready); end
    @(posedge clk); #1;
    upd0_valid = 0;
    @(negedge clk);
    checks++;
    if (q_count !== ((LAT == 2) ? 1 : 0)) begin
      errors++; $display("FAIL single_q_count_mid got %0d want %0d", q_count, (LAT == 2) ? 1 : 0);
    end
    for (int i = 0; i < 40 && wr_cyc_q.size() < 1; i++) begin @(negedge clk); #1; end
    checks++;
    if (wr_cyc_q.size() != 1) begin
      errors++; $display("FAIL single_write_count got %0d want 1", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] - acc != LAT) begin
        errors++; $display("FAIL single_latency got %0d want %0d", wr_cyc_q[0] - acc, LAT);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_count !== 0) begin errors++; $display("FAIL single_q_count_end got %0d want 0", q_count); end
  endtask

  task automatic test_dual();
    int acc;
    wr_cyc_q.delete();
    @(posedge clk); #1;
    upd0_valid = 1; upd0_pc = 32'h10; upd0_taken = 0;
    upd1_valid = 1; upd1_pc = 32'h20; upd1_taken = 1;
    acc = cyc;
    exp_q.push_back(mk_exp(32'h10, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(32'h20, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if ({upd0_ready, upd1_ready} !== 2'b11) begin
      errors++; $display("FAIL dual_ready got %b want 11", {upd0_ready, upd1_ready});
    end
    @(posedge clk); #1;
    upd0_valid = 0; upd1_valid = 0;
    for (int i = 0; i < 40 && wr_cyc_q.size() < 2; i++) begin @(negedge clk); #1; end
    checks++;
    if (wr_cyc_q.size() != 2) begin
      errors++; $display("FAIL dual_write_count got %0d want 2", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] - acc != LAT || wr_cyc_q[1] - acc != LAT + 1) begin
        errors++;
        $display("FAIL dual_timing got %0d,%0d want %0d,%0d", wr_cyc_q[0] - acc, wr_cyc_q[1] - acc, LAT, LAT + 1);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc;
    logic [WIDTH-1:0] pc;
    logic tk;
    wr_cyc_q.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pc = WIDTH'($urandom);
      tk = 1'($urandom_range(0, 1));
      if (i == 0) acc = cyc;
      upd0_valid = 1; upd0_pc = pc; upd0_taken = tk;
      exp_q.push_back(mk_exp(pc, tk, 1'b0));
    end
    @(posedge clk); #1;
    upd0_valid = 0;
    for (int i = 0; i < 40 && wr_cyc_q.size() < 6; i++) begin @(negedge clk); #1; end
    checks++;
    if (wr_cyc_q.size() != 6) begin
      errors++; $display("FAIL b2b_write_count got %0d want 6", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] - acc != LAT) begin
        errors++; $display("FAIL b2b_first_latency got %0d want %0d", wr_cyc_q[0] - acc, LAT);
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != 1) begin
          errors++; $display("FAIL b2b_gap[%0d] got %0d want 1", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_count !== 0) begin errors++; $display("FAIL b2b_q_count got %0d want 0", q_count); end
  endtask

  task automatic test_full();
    wr_cyc_q.delete();
    @(posedge clk); #1;
    tbl_busy = 1;
    for (int i = 0; i < 3; i++) begin
      upd0_valid = 1; upd0_pc = WIDTH'(32'h40 + i); upd0_taken = i[0];
      exp_q.push_back(mk_exp(WIDTH'(32'h40 + i), i[0], 1'b0));
      @(posedge clk); #1;
    end
    upd0_pc = 32'h43; upd0_taken = 1;
    upd1_valid = 1; upd1_pc = 32'h99; upd1_taken = 1;
    exp_q.push_back(mk_exp(32'h43, 1'b1, 1'b0));
    @(negedge clk);
    checks++;
    if (q_count !== 3) begin errors++; $display("FAIL full_q3 got %0d want 3", q_count); end
    checks++;
    if ({upd0_ready, upd1_ready} !== 2'b10) begin
      errors++; $display("FAIL full_ready_free1 got %b want 10", {upd0_ready, upd1_ready});
    end
    @(posedge clk); #1;
    upd0_pc = 32'h77;
    @(negedge clk);
    checks++;
    if (q_count !== 4) begin errors++; $display("FAIL full_q4 got %0d want 4", q_count); end
    checks++;
    if ({upd0_ready, upd1_ready} !== 2'b00) begin
      errors++; $display("FAIL full_ready_free0 got %b want 00", {upd0_ready, upd1_ready});
    end
    @(posedge clk); #1;
    tbl_busy = 0;
    @(negedge clk);
    checks++;
    if (upd0_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pop_cycle got %b want 0", upd0_ready); end
    @(posedge clk); #1;
    upd0_valid = 0; upd1_valid = 0;
    for (int i = 0; i < 40 && wr_cyc_q.size() < 4; i++) begin @(negedge clk); #1; end
    checks++;
    if (wr_cyc_q.size() != 4) begin
      errors++; $display("FAIL full_write_count got %0d want 4", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[3] - wr_cyc_q[0] != 3) begin
        errors++; $display("FAIL full_drain_span got %0d want 3", wr_cyc_q[3] - wr_cyc_q[0]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_count !== 0) begin errors++; $display("FAIL full_q_end got %0d want 0", q_count); end
  endtask

  task automatic test_clear();
    wr_cyc_q.delete(); done_cyc_q.delete();
    @(posedge clk); #1;
    tbl_busy = 1;
    upd0_valid = 1; upd0_pc = 32'h55; upd0_taken = 1;
    upd1_valid = 1; upd1_pc = 32'h66; upd1_taken = 0;
    exp_q.push_back(mk_exp(32'h55, 1'b1, 1'b0));
    exp_q.push_back(mk_exp(32'h66, 1'b0, 1'b0));
    @(posedge clk); #1;
    upd0_valid = 0; upd1_valid = 0;
    @(negedge clk);
    checks++;
    if (q_count !== 2) begin errors++; $display("FAIL clear_q_before got %0d want 2", q_count); end
    @(posedge clk); #1;
    clear_req = 1; tbl_busy = 0;
    for (int i = NIDX - 1; i >= 0; i--) exp_q.push_front(mk_exp(WIDTH'(i), 1'b0, 1'b1));
    @(posedge clk); #1;
    clear_req = 0;
    for (int i = 0; i < 40 && wr_cyc_q.size() < 10; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    tbl_busy = 1; clear_req = 1;
    upd1_valid = 1; upd1_pc = 32'hAB; upd1_taken = 1;
    exp_q.push_back(mk_exp(32'hAB, 1'b1, 1'b0));
    @(posedge clk); #1;
    clear_req = 0; upd1_valid = 0;
    @(posedge clk); #1;
    tbl_busy = 0;
    for (int i = 0; i < 700 && wr_cyc_q.size() < NIDX + 3; i++) begin @(negedge clk); #1; end
    checks++;
    if (wr_cyc_q.size() != NIDX + 3) begin
      errors++; $display("FAIL clear_write_count got %0d want %0d", wr_cyc_q.size(), NIDX + 3);
    end else begin
      checks++;
      if (wr_cyc_q[NIDX-1] - wr_cyc_q[0] != NIDX + 1) begin
        errors++; $display("FAIL clear_sweep_span got %0d want %0d", wr_cyc_q[NIDX-1] - wr_cyc_q[0], NIDX + 1);
      end
      checks++;
      if (done_cyc_q.size() != 1) begin
        errors++; $display("FAIL clear_done_count got %0d want 1", done_cyc_q.size());
      end else begin
        checks++;
        if (done_cyc_q[0] != wr_cyc_q[NIDX-1] + 1) begin
          errors++; $display("FAIL clear_done_cycle got %0d want %0d", done_cyc_q[0], wr_cyc_q[NIDX-1] + 1);
        end
        checks++;
        if (wr_cyc_q[NIDX] <= done_cyc_q[0]) begin
          errors++; $display("FAIL clear_queued_after_done got %0d want >%0d", wr_cyc_q[NIDX], done_cyc_q[0]);
        end
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_count !== 0) begin errors++; $display("FAIL clear_q_end got %0d want 0", q_count); end
  endtask

  task automatic test_reset_mid_sweep();
    int found;
    int acc;
    wr_cyc_q.delete(); done_cyc_q.delete();
    @(posedge clk); #1;
    clear_req = 1;
    for (int i = 0; i < NIDX; i++) exp_q.push_back(mk_exp(WIDTH'(i), 1'b0, 1'b1));
    @(posedge clk); #1;
    clear_req = 0;
    upd0_valid = 1; upd0_pc = 32'h3C; upd0_taken = 1;
    @(posedge clk); #1;
    upd0_valid = 0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk); #1;
      if (tbl_wr_en === 1'b1 && tbl_wr_clr === 1'b1 && tbl_wr_idx === IDX_BITS'(7)) found = 1;
    end
    checks++;
    if (found != 1) begin errors++; $display("FAIL rst_mid_reach_idx7 got %0d want 1", found); end
    checks++;
    if (q_count !== 1) begin errors++; $display("FAIL rst_mid_q_before got %0d want 1", q_count); end
    rst = 1'b0;
    #1;
    checks++;
    if ({tbl_wr_en, tbl_wr_idx, tbl_wr_taken, tbl_wr_clr, clear_done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %0h want 0", {tbl_wr_en, tbl_wr_idx, tbl_wr_taken, tbl_wr_clr, clear_done});
    end
    checks++;
    if (q_count !== 0) begin errors++; $display("FAIL rst_mid_q_count got %0d want 0", q_count); end
    exp_q.delete();
    wr_cyc_q.delete(); done_cyc_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (done_cyc_q.size() != 0 || wr_cyc_q.size() != 0) begin
      errors++; $display("FAIL rst_mid_quiet got done=%0d wr=%0d want 0,0", done_cyc_q.size(), wr_cyc_q.size());
    end
    @(posedge clk); #1;
    upd0_valid = 1; upd0_pc = 32'h5A; upd0_taken = 0;
    acc = cyc;
    exp_q.push_back(mk_exp(32'h5A, 1'b0, 1'b0));
    @(posedge clk); #1;
    upd0_valid = 0;
    for (int i = 0; i < 40 && wr_cyc_q.size() < 1; i++) begin @(negedge clk); #1; end
    checks++;
    if (wr_cyc_q.size() != 1) begin
      errors++; $display("FAIL rst_mid_idle_write got %0d want 1", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] - acc != LAT) begin
        errors++; $display("FAIL rst_mid_idle_latency got %0d want %0d", wr_cyc_q[0] - acc, LAT);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_back_to_back();
    test_full();
    test_clear();
    test_reset_mid_sweep();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
